tri_bus_arbiter: RTL and testbench

- Round-robin arbiter that drives the 2-bit select of the 32-bit three-source tri-state mux on the datapath bus.
- Sits directly upstream of the mux. Three requesters place data on din_0..din_2 and raise req[i]; the arbiter chooses the owner and drives sel.
- Feeds the resolved mux_out back in and registers it, giving a qualified bus word (cap_data/cap_valid) to the consumer.
- Bounds bus tenure with a hold counter so no single requester can starve the others.

---
 rtl/tri_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_tri_bus_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner select for a three-source tri-state bus mux, with bounded tenure and registered bus capture.
// Latency: 1 cycle from request to grant; the captured bus word appears 1 cycle after the bus cycle.
// Backpressure: none. A requester holds req high to keep the bus. After MAX_HOLD cycles its tenure is forcibly rotated away.
// Optional feature: define TRI_BUS_ARB_PARK_EN to park sel on the last owner while idle, instead of 11.
module tri_bus_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] mux_out,
    output logic [1:0]       sel,
    output logic [2:0]       grant,
    output logic             busy,
    output logic             preempt,
    output logic [WIDTH-1:0] cap_data,
    output logic             cap_valid
);

    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    // The pointer doubles as the current owner while in GRANT, because every grant moves it to the new owner.
    logic [1:0]      ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            preempt_d;
    logic [1:0]      pick;
    logic            owner_req;
    logic            cap_hit;
    logic [1:0]      sel_d;
    logic [2:0]      grant_d;

`ifdef TRI_BUS_ARB_PARK_EN
    // Set by the first grant after reset. Until then there is no last owner to park on.
    logic            parked_q;
`endif

    // Search order from pointer p is p+1, p+2, then p itself.
    // As a result, the last owner is always the lowest-priority candidate.
    function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = (p == 2'd2) ? 2'd0 : p + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (r[c1])      return c1;
        else if (r[c2]) return c2;
        else            return p;
    endfunction

    // Next-state logic covers normal release, direct hand-over, and timeout rotation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        pick      = rr_pick(ptr_q, req);
        owner_req = req[ptr_q];
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    ptr_d   = pick;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    hold_d = '0;
                    if (|req) begin
                        ptr_d = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (hold_q == HOLD_LAST) begin
                    // Forced release. If the owner is the only requester, rr_pick returns the owner,
                    // so it is re-granted with a fresh hold count.
                    preempt_d = 1'b1;
                    ptr_d     = pick;
                    hold_d    = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // Decode the registered outputs from the next state, so that every output is a flop.
    always_comb begin
        grant_d = (state_d == GRANT) ? (3'b001 << ptr_d) : 3'b000;
        cap_hit = (state_q == GRANT) && owner_req;
`ifdef TRI_BUS_ARB_PARK_EN
        sel_d   = (state_d == GRANT || parked_q) ? ptr_d : 2'b11;
`else
        sel_d   = (state_d == GRANT) ? ptr_d : 2'b11;
`endif
    end

    // Arbitration state and outputs.
    // Reset is asynchronous, so ownership drops immediately and the bus floats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd2;
            hold_q    <= '0;
            sel       <= 2'b11;
            grant     <= 3'b000;
            busy      <= 1'b0;
            preempt   <= 1'b0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            sel       <= sel_d;
            grant     <= grant_d;
            busy      <= (state_d == GRANT);
            preempt   <= preempt_d;
            cap_valid <= cap_hit;
            if (cap_hit) begin
                cap_data <= mux_out;
            end
        end
    end

`ifdef TRI_BUS_ARB_PARK_EN
    // Remember that at least one grant has happened, which enables parking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parked_q <= 1'b0;
        end else if (state_d == GRANT) begin
            parked_q <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Randomized and directed stimulus for tri_bus_arbiter, checked against a behavioural model.
// Every cycle compares all six outputs; the model is an owner index with a round-robin search.
// The bench runs with MAX_HOLD=4 so that timeouts occur often.
module tb_tri_bus_arbiter;

    localparam int W  = 32;
    localparam int MH = 4;

    logic         clk;
    logic         rst_n;
    logic [2:0]   req;
    logic [W-1:0] din [3];
    logic [W-1:0] mux_out;
    logic [1:0]   sel;
    logic [2:0]   grant;
    logic         busy;
    logic         preempt;
    logic [W-1:0] cap_data;
    logic         cap_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Behavioural model state. m_owner is -1 when idle.
    int           m_owner;
    int           m_ptr;
    int           m_hold;
    bit           m_pre;
    bit           m_cv;
    logic [W-1:0] m_cd;
    bit           m_parked;

    tri_bus_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mux_out   (mux_out),
        .sel       (sel),
        .grant     (grant),
        .busy      (busy),
        .preempt   (preempt),
        .cap_data  (cap_data),
        .cap_valid (cap_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The tri-state mux itself. When nothing drives the bus, it returns a junk word.
    always_comb begin
        case (sel)
            2'd0:    mux_out = din[0];
            2'd1:    mux_out = din[1];
            2'd2:    mux_out = din[2];
            default: mux_out = 32'hDEAD_BEEF;
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic int pick(input int p, input logic [2:0] r);
        for (int k = 1; k <= 3; k++) begin
            if (r[(p + k) % 3]) return (p + k) % 3;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_ptr    = 2;
        m_hold   = 0;
        m_pre    = 0;
        m_cv     = 0;
        m_cd     = '0;
        m_parked = 0;
    endtask

    task automatic give_to(input int c);
        m_owner  = c;
        m_ptr    = c;
        m_hold   = 0;
        m_parked = 1;
    endtask

    // One clock edge of the arbitration rules, applied to the request pattern sampled at that edge.
    task automatic model_step();
        logic [2:0] r;
        r = req;
        m_pre = 0;
        if (m_owner >= 0 && r[m_owner]) begin
            m_cv = 1;
            m_cd = din[m_owner];
        end else begin
            m_cv = 0;
        end
        if (m_owner < 0) begin
            if (r != 0) give_to(pick(m_ptr, r));
        end else if (!r[m_owner]) begin
            if (r != 0) give_to(pick(m_ptr, r));
            else        m_owner = -1;
        end else if (m_hold == MH - 1) begin
            m_pre = 1;
            give_to(pick(m_ptr, r));
        end else begin
            m_hold++;
        end
    endtask

    task automatic check_all();
        logic [1:0] es;
        logic [2:0] eg;
        eg = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
        if (m_owner >= 0) es = 2'(m_owner);
`ifdef TRI_BUS_ARB_PARK_EN
        else if (m_parked) es = 2'(m_ptr);
`endif
        else es = 2'b11;
        check_eq("sel",       32'(sel),       32'(es));
        check_eq("grant",     32'(grant),     32'(eg));
        check_eq("busy",      32'(busy),      32'(m_owner >= 0));
        check_eq("preempt",   32'(preempt),   32'(m_pre));
        check_eq("cap_valid", 32'(cap_valid), 32'(m_cv));
        check_eq("cap_data",  cap_data,       m_cd);
    endtask

    // Called at a negedge: drive the inputs, step the model at the posedge, then check at the next negedge.
    task automatic cycle(input logic [2:0] r);
        req = r;
        for (int i = 0; i < 3; i++) din[i] = $urandom;
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [2:0] r;
        rst_n = 1'b0;
        req   = 3'b000;
        for (int i = 0; i < 3; i++) din[i] = '0;
        model_reset();
        #12;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) cycle(3'b000);

        // A single requester for three cycles, followed by release.
        for (int i = 0; i < 3; i++) cycle(3'b010);
        for (int i = 0; i < 2; i++) cycle(3'b000);

        // All three requesters at once. Each owner drops its request after two grant cycles.
        r = 3'b111;
        for (int i = 0; i < 10; i++) begin
            if (m_owner >= 0 && m_hold == 1) r[m_owner] = 1'b0;
            cycle(r);
        end

        // Two constant requesters rotate on timeout.
        for (int i = 0; i < 14; i++) cycle(3'b101);
        for (int i = 0; i < 2; i++) cycle(3'b000);

        // A sole constant requester is re-granted on every timeout.
        for (int i = 0; i < 13; i++) cycle(3'b001);

        // Reset in the middle of a tenure.
        cycle(3'b000);
        for (int i = 0; i < 2; i++) cycle(3'b010);
        check_eq("pre_reset_grant", 32'(grant), 32'h2);
        #2 rst_n = 1'b0;
        req = 3'b000;
        #1;
        model_reset();
        check_all();
        #1 rst_n = 1'b1;
        @(negedge clk);
        cycle(3'b011);
        check_eq("post_reset_grant", 32'(grant), 32'h1);

        // Sticky random requests, which produce a mix of hand-overs, timeouts and idles.
        r = 3'b000;
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            end
            cycle(r);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
